// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding one byte at a time from 4 requesters to a Tx engine
//   clk, rst (async, active-high) | req[3:0], lock[3:0], data_in[31:0] (byte i at [8i+7:8i])
//   txrdy from engine | load, data_out[7:0], ack[3:0] pulses | busy, grant_id[1:0], err
module tx_arbiter #(
  parameter int TMO = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [31:0] data_in,
  output logic [3:0]  ack,
  input  logic        txrdy,
  output logic        load,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH} state_t;
  localparam int CW = $clog2(TMO + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] win;
  logic relock;
  // descending loop so the nearest requester after grant_id overrides farther ones
  always_comb begin
    win = grant_id;
    for (int k = 4; k >= 1; k--)
      if (req[grant_id + 2'(k)]) win = grant_id + 2'(k);
  end
  assign relock = lock[grant_id] & req[grant_id];
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      load     <= 1'b0;
      ack      <= 4'b0;
      err      <= 1'b0;
      data_out <= 8'h00;
      grant_id <= 2'd3;
      cnt      <= '0;
    end else begin
      load <= 1'b0;
      ack  <= 4'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (txrdy && |req) begin
          grant_id <= win;
          data_out <= data_in[8*win +: 8];
          load     <= 1'b1;
          ack      <= 4'b1 << win;
          state    <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT_LOW;
        end
        WAIT_LOW: if (!txrdy) state <= WAIT_HIGH;
          else if (cnt == CW'(TMO - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        WAIT_HIGH: if (txrdy) begin
          if (relock) begin
            data_out <= data_in[8*grant_id +: 8];
            load     <= 1'b1;
            ack      <= 4'b1 << grant_id;
            state    <= LOAD;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scoreboard bench for tx_arbiter with a transaction-level arbitration model
module tb_tx_arbiter;
  logic clk = 0, rst = 1, txrdy = 0;
  logic [3:0] req = 0, lock = 0, ack;
  logic [31:0] data_in = 0;
  logic load, busy, err;
  logic [7:0] data_out;
  logic [1:0] grant_id;
  typedef struct packed {logic [1:0] g; logic [7:0] b;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  bit err_ok = 0, from_wh = 0;
  logic [1:0] mg = 2'd3;
  always #5 clk = ~clk;
  tx_arbiter #(.TMO(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .data_in(data_in), .ack(ack),
    .txrdy(txrdy), .load(load), .data_out(data_out), .busy(busy), .grant_id(grant_id), .err(err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (load) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load actual_grant=%0d required=no_load", grant_id);
      end else begin
        e = q.pop_front();
        chk("grant", 32'(grant_id), 32'(e.g));
        chk("data_out", 32'(data_out), 32'(e.b));
        chk("ack", 32'(ack), 32'(4'b1 << e.g));
      end
    end else chk("ack_quiet", 32'(ack), 0);
    if (!err_ok) chk("err_quiet", 32'(err), 0);
  end
  // lock only keeps the engine when coming straight out of a completed transfer
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [3:0] l);
    if (from_wh && l[mg] && r[mg]) return mg;
    for (int k = 1; k <= 4; k++)
      if (r[(int'(mg) + k) % 4]) return 2'((int'(mg) + k) % 4);
    return mg;
  endfunction
  task automatic wait_load();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = load;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL load_timeout actual=no_load required=load");
      q.delete();
    end
  endtask
  task automatic issue(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
    exp_t x;
    req = r;
    lock = l;
    data_in = d;
    x.g = pick(r, l);
    x.b = d[8*x.g +: 8];
    q.push_back(x);
    mg = x.g;
    txrdy = 1;
    wait_load();
  endtask
  task automatic tail();
    int dly = $urandom_range(0, 2);
    int low = $urandom_range(2, 4);
    repeat (dly) begin
      @(negedge clk);
      req = 4'($urandom);
    end
    txrdy = 0;
    repeat (low) begin
      @(negedge clk);
      req = 4'($urandom);
      lock = 4'($urandom);
      data_in = $urandom;
    end
    from_wh = 1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_load"}, 32'(load), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_data_out"}, 32'(data_out), 0);
    chk({tag, "_grant_id"}, 32'(grant_id), 3);
  endtask
  initial begin
    exp_t x;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 0;
    req = 4'b0001;
    repeat (5) begin
      @(negedge clk);
      chk("no_load_txrdy0", 32'(load), 0);
    end
    x.g = pick(4'b0001, 4'b0000);
    x.b = data_in[8*x.g +: 8];
    q.push_back(x);
    mg = x.g;
    txrdy = 1;
    @(posedge clk);
    #1 chk("latency_load", 32'(load), 1);
    @(negedge clk);
    tail();
    repeat (4) begin
      issue(4'b0101, 4'b0000, $urandom);
      tail();
    end
    repeat (8) begin
      issue(4'b1111, 4'b0000, 32'h44332211);
      tail();
    end
    issue(4'b0001, 4'b0000, $urandom);
    tail();
    repeat (3) begin
      issue(4'b0011, 4'b0010, $urandom);
      tail();
    end
    issue(4'b0011, 4'b0000, $urandom);
    tail();
    issue(4'b0100, 4'b0000, $urandom);
    err_ok = 1;
    repeat (4) begin
      @(negedge clk);
      req = 4'b0000;
      chk("err_early", 32'(err), 0);
    end
    @(negedge clk);
    chk("err_pulse", 32'(err), 1);
    chk("busy_after_tmo", 32'(busy), 0);
    @(negedge clk);
    chk("err_single", 32'(err), 0);
    err_ok = 0;
    from_wh = 0;
    issue(4'b1111, 4'b0000, $urandom);
    tail();
    #2 rst = 1;
    #1 chk_reset("async_rst");
    chk("queue_at_rst", q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    mg = 2'd3;
    from_wh = 0;
    repeat (3) @(negedge clk);
    issue(4'b1000, 4'b0000, $urandom);
    tail();
    repeat (40) begin
      issue(4'($urandom_range(1, 15)), 4'($urandom), $urandom);
      tail();
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 The block SHALL have parameter TMO, default 4: the maximum number of cycles WAIT_LOW waits for txrdy to fall.
REQ-002 The block SHALL have the port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have the port req, input, 4 bits: req[i] high means requester i has a byte pending.
REQ-005 The block SHALL have the port lock, input, 4 bits: lock[i] high asks to keep the engine for requester i's next byte.
REQ-006 The block SHALL have the port data_in, input, 32 bits: requester i's byte on data_in[8i+7:8i].
REQ-007 The block SHALL have the port ack, output, 4 bits: a one-cycle pulse on ack[i] when requester i's byte is taken.
REQ-008 The block SHALL have the port txrdy, input, 1 bit: the ready flag from the Tx engine.
REQ-009 The block SHALL have the port load, output, 1 bit: a one-cycle load strobe to the Tx engine.
REQ-010 The block SHALL have the port data_out, output, 8 bits: the byte presented to the Tx engine, valid while load is high.
REQ-011 The block SHALL have the port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have the port grant_id, output, 2 bits: the index of the most recently granted requester.
REQ-013 The block SHALL have the port err, output, 1 bit: a one-cycle pulse on WAIT_LOW timeout.

Function
REQ-014 The block SHALL implement exactly four states: IDLE, LOAD, WAIT_LOW and WAIT_HIGH; busy = (state != IDLE).
REQ-015 In IDLE, the block SHALL arbitrate only when txrdy=1 and req != 0; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: search order starts at (grant_id+1) mod 4 and ascends with wrap, and the first set req bit wins.
REQ-017 On the winning edge, the block SHALL capture the winner in grant_id, capture its byte in data_out, and move to LOAD.
REQ-018 In LOAD, load=1 and ack[grant_id]=1 for exactly that one cycle; the next state SHALL be WAIT_LOW.
REQ-019 WAIT_LOW SHALL exit to WAIT_HIGH on the first cycle txrdy=0.
REQ-020 If txrdy is still 1 after TMO cycles in WAIT_LOW, the block SHALL pulse err for one cycle and go to IDLE; grant_id SHALL be retained.
REQ-021 WAIT_HIGH SHALL wait for txrdy=1. When txrdy=1 and lock[grant_id]=1 and req[grant_id]=1, the block SHALL re-grant the same requester: capture data_out and go straight to LOAD.
REQ-022 When txrdy=1 in WAIT_HIGH without that lock condition, the block SHALL go to IDLE; arbitration resumes there on the next cycle.
REQ-023 Latency SHALL be: req seen in IDLE at edge N, load high in cycle N+1.
REQ-024 data_out SHALL hold its value from LOAD until the next capture.
REQ-025 req, lock and data_in changes outside the capture edge SHALL have no effect; a req dropped before capture is not served.
REQ-026 Any lock bit other than lock[grant_id] SHALL be ignored.
REQ-027 The block SHALL produce at most one ack bit and at most one load per transfer, and never two loads without an intervening WAIT_LOW.

Reset
REQ-028 While rst=1: state=IDLE, load=0, ack=0, err=0, busy=0, data_out=8'h00, grant_id=2'd3 (so requester 0 wins first), and the timeout counter=0.
REQ-029 A reset asserted mid-transfer SHALL abort immediately; no load or ack pulse SHALL follow the reset release unless a new arbitration occurs.
REQ-030 The first arbitration after reset SHALL require txrdy=1.

Verification
REQ-031 With txrdy=1 and req=4'b0101 held, the engine model answering every load: grants SHALL go 0,2,0,2, and data_out SHALL match each source byte.
REQ-032 With req=4'b1111, data_in=32'h44332211 and no lock: load SHALL appear one cycle after capture and data_out SHALL follow 8'h11, 8'h22, 8'h33, 8'h44, then repeat.
REQ-033 With lock=4'b0010 and req=4'b0011 held for three bytes, then lock dropped: grants SHALL be 1,1,1,0.
REQ-034 With txrdy stuck at 1 after load and TMO=4: err SHALL pulse once, 4 cycles after entering WAIT_LOW; state SHALL return to IDLE; the next grant SHALL be (grant_id+1) mod 4.
REQ-035 rst asserted in WAIT_HIGH: outputs SHALL return to their reset values asynchronously, and after release with req=4'b1000 the first grant SHALL be 3.
REQ-036 With txrdy=0 held in IDLE and req=4'b0001: no load SHALL occur until txrdy=1, then load SHALL follow exactly one cycle later.
